// File: rtl/fifo_pop_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_pop_stream_pkg : state type and default constants for fifo_pop_stream|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fifo_pop_stream_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_RD_LAT = 2;
  localparam int unsigned DEF_DEPTH  = 4;

endpackage
`default_nettype wire

// File: rtl/fifo_pop_stream_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pop_skid_buf : circular output buffer with head/tail pointers and count   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pop_skid_buf
  import fifo_pop_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic                   valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[tail_q] = wr_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (rd_en) begin
        head_d = head_q + PTR_W'(1);
      end
      // simultaneous write and read leaves the occupancy unchanged
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid     = (count_q != '0);
  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/fifo_pop_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_pop_stream : credit-based FIFO popper feeding a ready/valid stream.  |
// | Optional pop_cnt output with macro FIFO_POP_STREAM_CNT_EN.  Rev 1.0       |
// +--------------------------------------------------------------------------+
module fifo_pop_stream
  import fifo_pop_stream_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned RD_LAT = DEF_RD_LAT,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [WIDTH-1:0] rdata,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef FIFO_POP_STREAM_CNT_EN
  ,
  output logic [15:0]      pop_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]  inflight_cnt;
  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W:0]    credit_used;
  logic              buf_wr;
  logic              buf_flush;
  logic              xfer;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
    end
  end

  // Credits count words already buffered plus words still in the read pipe
  assign credit_used = {1'b0, buf_count} + {1'b0, inflight_cnt};
  assign rinc = rst_n && !rempty && (state_q == RUN) && !clear &&
                (credit_used < (CNT_W + 1)'(DEPTH));

  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = rinc;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  assign buf_wr    = inflight_q[RD_LAT-1] && (state_q == RUN) && !clear;
  assign buf_flush = clear && (state_q == RUN);
  assign xfer      = out_valid && out_ready && !clear;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (clear) state_d = FLUSH;
      FLUSH:   if (inflight_cnt == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  pop_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (buf_flush),
    .wr_en     (buf_wr),
    .wr_data   (rdata),
    .rd_en     (xfer),
    .valid     (out_valid),
    .head_data (out_data),
    .count     (buf_count)
  );

  assign busy = (buf_count != '0) || (inflight_q != '0) || (state_q == FLUSH);

`ifdef FIFO_POP_STREAM_CNT_EN
  logic [15:0] pop_cnt_q, pop_cnt_d;

  always_comb begin
    pop_cnt_d = pop_cnt_q;
    if (xfer) pop_cnt_d = pop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_cnt_q <= '0;
    else        pop_cnt_q <= pop_cnt_d;
  end

  assign pop_cnt = pop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_pop_stream : directed self-checking bench for fifo_pop_stream     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fifo_pop_stream;

  localparam int WIDTH  = 32;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int MEM    = 256;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             out_ready;
  logic             fifo_flush;
  logic             rempty;
  logic             rinc;
  logic             out_valid;
  logic             busy;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] out_data;
`ifdef FIFO_POP_STREAM_CNT_EN
  logic [15:0]      pop_cnt;
  int               xfers = 0;
`endif

  fifo_pop_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef FIFO_POP_STREAM_CNT_EN
    ,
    .pop_cnt   (pop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Read-side FIFO: registered read data visible RD_LAT cycles after the pop
  logic [WIDTH-1:0] fmem [MEM];
  logic [WIDTH-1:0] pipe [RD_LAT];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (rinc && !rempty) rd_ptr <= rd_ptr + 1;
    pipe[0] <= fmem[rd_ptr % MEM];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Behavioural model: every popped, not-discarded word with the cycle it becomes visible
  typedef struct {
    logic [WIDTH-1:0] w;
    int               vis;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] got_w[$];
  int               got_c[$];
  int               rinc_log[$];
  int cyc         = 0;
  int flush_until = -1;
  int last_pop    = -1000;
  int n_tests     = 0;
  int n_fail      = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    logic exp_valid, exp_rinc, exp_busy, flushing;
    if (!rst_n) begin
      chk("rst_rinc", WIDTH'(rinc), '0);
      chk("rst_out_valid", WIDTH'(out_valid), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", WIDTH'(busy), '0);
`ifdef FIFO_POP_STREAM_CNT_EN
      chk("rst_pop_cnt", WIDTH'(pop_cnt), '0);
      xfers = 0;
`endif
      q.delete();
      flush_until = -1;
      last_pop    = -1000;
      cyc++;
      return;
    end
    flushing  = (cyc <= flush_until);
    exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
    exp_rinc  = !rempty && !clear && !flushing && (q.size() < DEPTH);
    exp_busy  = (q.size() > 0) || flushing;
    chk("out_valid", WIDTH'(out_valid), WIDTH'(exp_valid));
    chk("rinc", WIDTH'(rinc), WIDTH'(exp_rinc));
    chk("busy", WIDTH'(busy), WIDTH'(exp_busy));
    if (exp_valid) chk("out_data", out_data, q[0].w);
`ifdef FIFO_POP_STREAM_CNT_EN
    chk("pop_cnt", WIDTH'(pop_cnt), WIDTH'(xfers % 65536));
`endif
    if (rinc) rinc_log.push_back(cyc);
    if (clear && !flushing) begin
      q.delete();
      flush_until = (cyc + 1 > last_pop + RD_LAT + 1) ? cyc + 1 : last_pop + RD_LAT + 1;
    end else if (exp_valid && out_ready) begin
      got_w.push_back(q[0].w);
      got_c.push_back(cyc);
      void'(q.pop_front());
`ifdef FIFO_POP_STREAM_CNT_EN
      xfers++;
`endif
    end
    if (rinc && !rempty) begin
      q.push_back('{fmem[rd_ptr % MEM], cyc + RD_LAT + 1});
      last_pop = cyc;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fmem[wr_ptr % MEM] = w;
    wr_ptr++;
  endtask

  task automatic wait_deliv(input int base, input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((got_w.size() - base < n) && (k < budget)) begin
      step();
      k++;
    end
    if (got_w.size() - base < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: delivered %0d required %0d", name, got_w.size() - base, n);
    end
  endtask

  initial begin
    int gb, rb, k;
    for (int j = 0; j < MEM; j++) fmem[j] = '0;
    rst_n      = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    fifo_flush = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();

    // Streaming at full rate: 1..8 back to back, first word 3 cycles after first rinc
    gb = got_w.size();
    rb = rinc_log.size();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(WIDTH'(i));
    wait_deliv(gb, 8, 60, "t1_drain");
    for (int i = 0; i < 8; i++) chk("t1_word", got_w[gb+i], WIDTH'(i + 1));
    chk("t1_latency", WIDTH'(got_c[gb] - rinc_log[rb]), 3);
    chk("t1_consecutive", WIDTH'(got_c[gb+7] - got_c[gb]), 7);
    repeat (3) step();

    // Stalled output: exactly DEPTH pops, head shows word0
    gb = got_w.size();
    rb = rinc_log.size();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(32'h100 + WIDTH'(i));
    repeat (15) step();
    chk("t2_rinc_count", WIDTH'(rinc_log.size() - rb), 4);
    chk("t2_out_valid", WIDTH'(out_valid), 1);
    chk("t2_out_data", out_data, 32'h100);
    out_ready = 1'b1;
    wait_deliv(gb, 10, 80, "t2_drain");
    for (int i = 0; i < 10; i++) chk("t2_word", got_w[gb+i], 32'h100 + WIDTH'(i));
    repeat (3) step();

    // Toggling ready over 20 words
    gb = got_w.size();
    for (int i = 0; i < 20; i++) push_word(32'h300 + WIDTH'(i));
    k = 0;
    while ((got_w.size() - gb < 20) && (k < 200)) begin
      out_ready = ~out_ready;
      step();
      k++;
    end
    if (got_w.size() - gb < 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL t3_drain timeout: delivered %0d required 20", got_w.size() - gb);
    end
    for (int i = 0; i < 20; i++) chk("t3_word", got_w[gb+i], 32'h300 + WIDTH'(i));
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    repeat (4) step();

    // Clear with 2 buffered and 2 in flight
    gb = got_w.size();
    rb = rinc_log.size();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h400 + WIDTH'(i));
    k = 0;
    while ((rinc_log.size() - rb < 4) && (k < 30)) begin
      step();
      k++;
    end
    chk("t4_pops_before_clear", WIDTH'(rinc_log.size() - rb), 4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4_out_valid_after_clear", WIDTH'(out_valid), 0);
    chk("t4_busy_in_flush", WIDTH'(busy), 1);
    out_ready = 1'b1;
    wait_deliv(gb, 4, 60, "t4_drain");
    for (int i = 0; i < 4; i++) chk("t4_word", got_w[gb+i], 32'h404 + WIDTH'(i));
    repeat (3) step();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) push_word(32'h500 + WIDTH'(i));
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rinc", WIDTH'(rinc), 0);
    chk("t5_async_out_valid", WIDTH'(out_valid), 0);
    chk("t5_async_out_data", out_data, 0);
    chk("t5_async_busy", WIDTH'(busy), 0);
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
    rst_n = 1'b1;
    step();
    gb = got_w.size();
    push_word(32'hA);
    push_word(32'hB);
    wait_deliv(gb, 2, 30, "t5_drain");
    chk("t5_word0", got_w[gb], 32'hA);
    chk("t5_word1", got_w[gb+1], 32'hB);
    repeat (3) step();

`ifdef FIFO_POP_STREAM_CNT_EN
    // Counter wrap: 65537 transfers from reset leave pop_cnt at 1
    rst_n = 1'b0;
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
    rst_n = 1'b1;
    step();
    for (int j = 0; j < MEM; j++) fmem[j] = WIDTH'(j);
    gb = got_w.size();
    wr_ptr = wr_ptr + 65537;
    wait_deliv(gb, 65537, 66000, "t6_drain");
    repeat (2) step();
    chk("t6_pop_cnt_wrap", WIDTH'(pop_cnt), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_pop_stream.md
FIFO_POP_STREAM -- requirements
Module: fifo_pop_stream

Interface
REQ-001 Parameter WIDTH, default 32: data word width; matches the FIFO_syn read port.
REQ-002 Parameter RD_LAT, default 2: rclk cycles from an rinc pulse to the popped word being valid on rdata.
REQ-003 Parameter DEPTH, default 4, power of two and at least RD_LAT+1: output skid-buffer entries.
REQ-004 clk  input  1: read-domain clock (the FIFO rclk).
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 rempty  input  1: FIFO empty flag, same clock domain.
REQ-007 rinc  output  1: pop request to the FIFO.
REQ-008 rdata  input  WIDTH: FIFO read data, valid RD_LAT cycles after the pop.
REQ-009 clear  input  1: single-cycle pulse that discards buffered and in-flight words.
REQ-010 out_valid  output  1: output word available.
REQ-011 out_ready  input  1: downstream accepts the word.
REQ-012 out_data  output  WIDTH: output word.
REQ-013 busy  output  1: high whenever the buffer holds data, a read is in flight, or the state is FLUSH.

Function
REQ-014 rinc SHALL be asserted only when rempty=0, state=RUN, clear=0 and (buffer count + in-flight count) < DEPTH.
REQ-015 A RD_LAT-deep shift register SHALL track in-flight pops; when a pop's tag exits after RD_LAT cycles, rdata SHALL be written to the buffer tail.
REQ-016 out_valid SHALL equal (count != 0), and out_data SHALL be the head entry, driven from registers.
REQ-017 A transfer SHALL occur when out_valid=1 and out_ready=1; the head then advances.
REQ-018 A write and a transfer in the same cycle SHALL leave count unchanged, including when count=DEPTH.
REQ-019 Head and tail pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-020 The credit rule SHALL guarantee that the buffer never overflows, with no dependence on out_ready within the same cycle.
REQ-021 With out_ready held high and the FIFO non-empty, rinc SHALL stay high every cycle, giving a sustained throughput of 1 word/cycle.
REQ-022 Words SHALL leave the block in FIFO pop order, with no loss or duplication.
REQ-023 The state machine SHALL have two states, RUN and FLUSH:
- RUN -> FLUSH when clear=1.
- FLUSH -> RUN when the in-flight count is 0.
REQ-024 On clear, the buffer SHALL be emptied in the following cycle, out_valid SHALL fall, and any word arriving from an in-flight pop SHALL be dropped.
REQ-025 In FLUSH, rinc SHALL be 0; a clear pulse received in FLUSH SHALL be absorbed with no further effect.
REQ-026 clear has priority over a same-cycle transfer; that transfer is considered not to have occurred.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: rinc=0, out_valid=0, out_data=0, busy=0, state=RUN, count=0, pointers=0, in-flight register=0.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight words with no output glitch after release.

Configuration
REQ-029 With the macro FIFO_POP_STREAM_CNT_EN defined, the block SHALL add output pop_cnt (16 bits), reset to 0:
- It increments on each completed output transfer and wraps 0xFFFF -> 0.
- clear SHALL NOT reset it.
REQ-030 Without FIFO_POP_STREAM_CNT_EN, the pop_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the state enum type (RUN, FLUSH) and the default constants WIDTH=32, RD_LAT=2, DEPTH=4.
REQ-032 The buffer SHALL be a sub-module, pop_skid_buf (storage, pointers, count); the credit logic, in-flight tracking and state machine stay in the top module.

Verification
REQ-033 Reset, then preload the FIFO with 0x1..0x8 and hold out_ready=1 -> out_data = 0x1..0x8 on consecutive cycles, the first word 3 cycles after the first rinc.
REQ-034 Preload 10 words and hold out_ready=0 -> exactly 4 rinc pulses, out_valid=1 with out_data=word0, and no further pops until out_ready=1.
REQ-035 Toggle out_ready 1/0 every cycle over 20 words -> all 20 words delivered in order, count never exceeds 4.
REQ-036 Pulse clear while 2 reads are in flight and 2 words are buffered -> out_valid=0 next cycle, the 4 discarded words never appear, and the next output is the 5th FIFO word.
REQ-037 Assert rst_n=0 mid-stream for 1 cycle -> all outputs 0 asynchronously; after release, a fresh preload of 0xA,0xB is delivered as 0xA,0xB.
REQ-038 With FIFO_POP_STREAM_CNT_EN defined, transfer 65537 words -> pop_cnt=1.
